level_tracker: RTL and testbench

- Upstream feeder for the 6-bit level binary-to-BCD converter in the Tetris HUD path.
- Counts cleared lines, advances the level every 10 lines, and derives the gravity drop period for the piece-fall logic.
- Presents a stable 6-bit level word plus a 1-cycle gen strobe to the converter.
- Paces strobes so each conversion (7 cycles) finishes with its input held constant throughout.

---
 rtl/tetris_pkg.sv | 35 +++
 rtl/lvl_gen_pacer.sv | 57 +++++
 rtl/level_tracker.sv | 121 ++++++++++++
 tb/tb_level_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris HUD definitions: level FSM states, datapath widths and the
// gravity drop-period table used by both the level tracker and the gravity timer.
package tetris_pkg;

    localparam int LVL_W   = 6;
    localparam int LINES_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } lvl_state_e;

    // Frames per gravity step for a given level.
    function automatic logic [5:0] drop_period(input logic [LVL_W-1:0] lvl);
        logic [5:0] frames;
        if (lvl <= 6'd8) begin
            frames = 6'd48 - (lvl * 6'd5);
        end else if (lvl == 6'd9) begin
            frames = 6'd6;
        end else if (lvl <= 6'd12) begin
            frames = 6'd5;
        end else if (lvl <= 6'd15) begin
            frames = 6'd4;
        end else if (lvl <= 6'd18) begin
            frames = 6'd3;
        end else if (lvl <= 6'd28) begin
            frames = 6'd2;
        end else begin
            frames = 6'd1;
        end
        return frames;
    endfunction

endpackage

// File: rtl/lvl_gen_pacer.sv
// Paces conversion strobes to the level BCD converter: latches the level word
// and holds it frozen for GEN_HOLD cycles after every strobe.
module lvl_gen_pacer
    import tetris_pkg::*;
#(
    parameter int GEN_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] disp_level,
    output logic             lvl_gen
);

    localparam int                HOLD_W    = $clog2(GEN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(GEN_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              gen_pend_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [LVL_W-1:0]  disp_r;
    logic              gen_r;
    logic              fire_s;

    assign fire_s = gen_pend_r && (hold_cnt_r == HOLD_ZERO);

    // A request arriving on the firing cycle re-arms gen_pend for the next window.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_pend_r <= 1'b0;
            hold_cnt_r <= HOLD_ZERO;
            disp_r     <= {LVL_W{1'b0}};
            gen_r      <= 1'b0;
        end else begin
            gen_r <= fire_s;
            if (fire_s) begin
                disp_r     <= level;
                hold_cnt_r <= HOLD_INIT;
                gen_pend_r <= req;
            end else begin
                disp_r     <= disp_r;
                gen_pend_r <= gen_pend_r | req;
                if (hold_cnt_r != HOLD_ZERO) begin
                    hold_cnt_r <= hold_cnt_r - HOLD_ONE;
                end else begin
                    hold_cnt_r <= hold_cnt_r;
                end
            end
        end
    end

    assign disp_level = disp_r;
    assign lvl_gen    = gen_r;

endmodule

// File: rtl/level_tracker.sv
// Tetris level tracker: counts cleared lines, advances the level, derives the
// gravity drop period and feeds a paced level word to the BCD converter.
module level_tracker
    import tetris_pkg::*;
#(
    parameter int MAX_LEVEL     = 63,
    parameter int LINES_PER_LVL = 10,
    parameter int GEN_HOLD      = 8,
    parameter int MAX_LINES     = 999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               game_over,
    input  logic [LVL_W-1:0]   start_lvl,
    input  logic               clr_valid,
    input  logic [2:0]         clr_lines,
    output logic [LVL_W-1:0]   disp_level,
    output logic               lvl_gen,
    output logic [LINES_W-1:0] lines_total,
    output logic [5:0]         drop_frames,
    output logic               running
);

    localparam logic [4:0]         LPL_C       = 5'(LINES_PER_LVL);
    localparam logic [LVL_W-1:0]   MAX_LVL_C   = LVL_W'(MAX_LEVEL);
    localparam logic [LINES_W-1:0] MAX_LINES_C = LINES_W'(MAX_LINES);

    lvl_state_e         state_r, state_next_s;
    logic [LVL_W-1:0]   level_r, level_next_s;
    logic [3:0]         line_cnt_r, line_cnt_next_s;
    logic [LINES_W-1:0] lines_total_r, lines_total_next_s;
    logic [5:0]         drop_r;
    logic               running_r;
    logic               req_s;
    logic               clr_ok_s;
    logic [4:0]         sum_s;
    logic [4:0]         wrap_s;
    logic [LINES_W-1:0] tot_sum_s;

    assign clr_ok_s  = clr_valid && (state_r == RUN) &&
                       (clr_lines >= 3'd1) && (clr_lines <= 3'd4);
    assign sum_s     = {1'b0, line_cnt_r} + {2'b00, clr_lines};
    assign wrap_s    = sum_s - LPL_C;
    assign tot_sum_s = lines_total_r + {7'd0, clr_lines};

    // Next-state and counter updates; game_start overrides clears and game_over.
    always_comb begin
        state_next_s       = state_r;
        level_next_s       = level_r;
        line_cnt_next_s    = line_cnt_r;
        lines_total_next_s = lines_total_r;
        req_s              = 1'b0;
        if (game_start) begin
            state_next_s       = RUN;
            level_next_s       = (start_lvl > MAX_LVL_C) ? MAX_LVL_C : start_lvl;
            line_cnt_next_s    = 4'd0;
            lines_total_next_s = {LINES_W{1'b0}};
            req_s              = 1'b1;
        end else begin
            if (clr_ok_s) begin
                if (sum_s >= LPL_C) begin
                    line_cnt_next_s = wrap_s[3:0];
                    // Level saturates silently: no converter request at the top.
                    if (level_r < MAX_LVL_C) begin
                        level_next_s = level_r + 6'd1;
                        req_s        = 1'b1;
                    end else begin
                        level_next_s = level_r;
                    end
                end else begin
                    line_cnt_next_s = sum_s[3:0];
                end
                lines_total_next_s = (tot_sum_s > MAX_LINES_C) ? MAX_LINES_C : tot_sum_s;
            end else begin
                lines_total_next_s = lines_total_r;
            end
            case (state_r)
                IDLE:    state_next_s = IDLE;
                RUN:     state_next_s = game_over ? OVER : RUN;
                OVER:    state_next_s = OVER;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            level_r       <= {LVL_W{1'b0}};
            line_cnt_r    <= 4'd0;
            lines_total_r <= {LINES_W{1'b0}};
            drop_r        <= 6'd48;
            running_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            level_r       <= level_next_s;
            line_cnt_r    <= line_cnt_next_s;
            lines_total_r <= lines_total_next_s;
            drop_r        <= drop_period(level_r);
            running_r     <= (state_next_s == RUN);
        end
    end

    lvl_gen_pacer #(
        .GEN_HOLD (GEN_HOLD)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .req        (req_s),
        .level      (level_r),
        .disp_level (disp_level),
        .lvl_gen    (lvl_gen)
    );

    assign lines_total = lines_total_r;
    assign drop_frames = drop_r;
    assign running     = running_r;

endmodule

// File: tb/tb_level_tracker.sv
// Bench for level_tracker: directed scenario tasks plus a randomized run against
// a reference model that tracks cumulative lines and strobe timing in cycles.
module tb_level_tracker;

    localparam int GEN_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       game_over = 1'b0;
    logic [5:0] start_lvl = 6'd0;
    logic       clr_valid = 1'b0;
    logic [2:0] clr_lines = 3'd0;
    logic [5:0] disp_level;
    logic       lvl_gen;
    logic [9:0] lines_total;
    logic [5:0] drop_frames;
    logic       running;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gen_count = 0;
    int gen_cyc_q[$];
    int gen_val_q[$];

    int m_level = 0, m_start = 0, m_acc = 0, m_total = 0, m_state = 0;
    int m_disp = 0, m_drop = 48, m_last = -100;
    bit m_pend = 1'b0, m_gen = 1'b0;

    always #5 clk = ~clk;

    level_tracker #(
        .MAX_LEVEL(63), .LINES_PER_LVL(10), .GEN_HOLD(GEN_HOLD), .MAX_LINES(999)
    ) dut (
        .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
        .start_lvl(start_lvl), .clr_valid(clr_valid), .clr_lines(clr_lines),
        .disp_level(disp_level), .lvl_gen(lvl_gen), .lines_total(lines_total),
        .drop_frames(drop_frames), .running(running)
    );

    function automatic int drop_ref(int l);
        if (l <= 8) return 48 - 5 * l;
        else if (l == 9) return 6;
        else if (l <= 12) return 5;
        else if (l <= 15) return 4;
        else if (l <= 18) return 3;
        else if (l <= 28) return 2;
        else return 1;
    endfunction

    // Advance the model by one cycle of inputs, then clock the DUT once.
    task automatic step();
        bit fire, req;
        int old;
        if (rst) begin
            m_level = 0; m_start = 0; m_acc = 0; m_total = 0; m_state = 0;
            m_disp = 0; m_drop = 48; m_last = -100; m_pend = 1'b0; m_gen = 1'b0;
        end else begin
            fire = m_pend && (cyc + 1 >= m_last + GEN_HOLD);
            if (fire) begin
                m_disp = m_level;
                m_last = cyc + 1;
            end
            m_drop = drop_ref(m_level);
            req = 1'b0;
            if (game_start) begin
                m_start = (int'(start_lvl) > 63) ? 63 : int'(start_lvl);
                m_level = m_start; m_acc = 0; m_total = 0; m_state = 1; req = 1'b1;
            end else begin
                if (clr_valid && m_state == 1 && clr_lines >= 3'd1 && clr_lines <= 3'd4) begin
                    old = m_level;
                    m_acc += int'(clr_lines);
                    m_total = (m_total + int'(clr_lines) > 999) ? 999 : m_total + int'(clr_lines);
                    m_level = m_start + m_acc / 10;
                    if (m_level > 63) m_level = 63;
                    req = (m_level != old);
                end
                if (game_over && m_state == 1) m_state = 2;
            end
            m_pend = fire ? req : (m_pend || req);
            m_gen = fire;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (lvl_gen === 1'b1) begin
            gen_count++;
            gen_cyc_q.push_back(cyc);
            gen_val_q.push_back(int'(disp_level));
        end
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic clear(int n);
        clr_valid = 1'b1; clr_lines = 3'(n);
        step();
        clr_valid = 1'b0; clr_lines = 3'd0;
    endtask

    task automatic start_game(int l);
        game_start = 1'b1; start_lvl = 6'(l);
        step();
        game_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; game_start = 1'b1; clr_valid = 1'b1; clr_lines = 3'd3; start_lvl = 6'd20;
        step(); step();
        rst = 1'b0; game_start = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0;
        total++; if (lvl_gen !== 1'b0) begin bad++; $display("FAIL reset_gen: got %0d want 0", lvl_gen); end
        total++; if (disp_level !== 6'd0) begin bad++; $display("FAIL reset_disp: got %0d want 0", disp_level); end
        total++; if (lines_total !== 10'd0) begin bad++; $display("FAIL reset_total: got %0d want 0", lines_total); end
        total++; if (drop_frames !== 6'd48) begin bad++; $display("FAIL reset_drop: got %0d want 48", drop_frames); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0d want 0", running); end
    endtask

    task automatic test_basic();
        int g;
        do_reset(); start_game(0); idle(12);
        for (int i = 0; i < 9; i++) begin clear(1); idle(1); end
        total++; if (dut.level_r !== 6'd0) begin bad++; $display("FAIL basic_level9: got %0d want 0", dut.level_r); end
        g = gen_count;
        clear(1);
        total++; if (dut.level_r !== 6'd1) begin bad++; $display("FAIL basic_level: got %0d want 1", dut.level_r); end
        total++; if (dut.line_cnt_r !== 4'd0) begin bad++; $display("FAIL basic_linecnt: got %0d want 0", dut.line_cnt_r); end
        total++; if (lvl_gen !== 1'b0) begin bad++; $display("FAIL basic_gen_early: got %0d want 0", lvl_gen); end
        step();
        total++; if (lvl_gen !== 1'b1) begin bad++; $display("FAIL basic_gen: got %0d want 1", lvl_gen); end
        total++; if (disp_level !== 6'd1) begin bad++; $display("FAIL basic_disp: got %0d want 1", disp_level); end
        total++; if (drop_frames !== 6'd43) begin bad++; $display("FAIL basic_drop: got %0d want 43", drop_frames); end
        idle(10);
        total++; if (gen_count - g !== 1) begin bad++; $display("FAIL basic_gen_count: got %0d want 1", gen_count - g); end
    endtask

    task automatic test_mid_level();
        do_reset(); start_game(5); idle(12);
        clear(4); clear(4); idle(2);
        total++; if (dut.line_cnt_r !== 4'd8) begin bad++; $display("FAIL mid_linecnt8: got %0d want 8", dut.line_cnt_r); end
        clear(4);
        total++; if (dut.level_r !== 6'd6) begin bad++; $display("FAIL mid_level: got %0d want 6", dut.level_r); end
        total++; if (dut.line_cnt_r !== 4'd2) begin bad++; $display("FAIL mid_linecnt: got %0d want 2", dut.line_cnt_r); end
        total++; if (lines_total !== 10'd12) begin bad++; $display("FAIL mid_total: got %0d want 12", lines_total); end
        step();
        total++; if (lvl_gen !== 1'b1) begin bad++; $display("FAIL mid_gen: got %0d want 1", lvl_gen); end
        total++; if (disp_level !== 6'd6) begin bad++; $display("FAIL mid_disp: got %0d want 6", disp_level); end
    endtask

    task automatic test_back_to_back();
        do_reset(); start_game(0); idle(12);
        clear(4); clear(4); idle(2);
        gen_cyc_q.delete(); gen_val_q.delete();
        clear(2); clear(4); clear(4); clear(2);
        for (int i = 0; i < 14; i++) begin
            step();
            if (gen_cyc_q.size() == 1) begin
                total++; if (disp_level !== 6'd1) begin bad++; $display("FAIL b2b_hold_disp: got %0d want 1", disp_level); end
            end
        end
        total++;
        if (gen_cyc_q.size() != 2) begin
            bad++; $display("FAIL b2b_strobes: got %0d want 2", gen_cyc_q.size());
        end else begin
            total++; if (gen_cyc_q[1] - gen_cyc_q[0] != GEN_HOLD) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", gen_cyc_q[1] - gen_cyc_q[0], GEN_HOLD); end
            total++; if (gen_val_q[0] != 1) begin bad++; $display("FAIL b2b_first: got %0d want 1", gen_val_q[0]); end
            total++; if (gen_val_q[1] != 2) begin bad++; $display("FAIL b2b_second: got %0d want 2", gen_val_q[1]); end
        end
    endtask

    task automatic test_max_level();
        int g;
        do_reset(); start_game(63); idle(12);
        g = gen_count;
        for (int i = 0; i < 20; i++) clear(int'($urandom_range(1, 4)));
        idle(12);
        total++; if (gen_count != g) begin bad++; $display("FAIL max_no_gen: got %0d want %0d", gen_count, g); end
        total++; if (dut.level_r !== 6'd63) begin bad++; $display("FAIL max_level: got %0d want 63", dut.level_r); end
        total++; if (drop_frames !== 6'd1) begin bad++; $display("FAIL max_drop: got %0d want 1", drop_frames); end
        total++; if (dut.line_cnt_r !== 4'(m_acc % 10)) begin bad++; $display("FAIL max_linecnt: got %0d want %0d", dut.line_cnt_r, m_acc % 10); end
        start_game(60); idle(12);
        for (int i = 0; i < 10; i++) clear(4);
        idle(12);
        total++; if (dut.level_r !== 6'd63) begin bad++; $display("FAIL max60_level: got %0d want 63", dut.level_r); end
        total++; if (disp_level !== 6'd63) begin bad++; $display("FAIL max60_disp: got %0d want 63", disp_level); end
        total++; if (dut.line_cnt_r !== 4'd0) begin bad++; $display("FAIL max60_linecnt: got %0d want 0", dut.line_cnt_r); end
    endtask

    task automatic test_illegal();
        do_reset(); clear(3);
        total++; if (lines_total !== 10'd0) begin bad++; $display("FAIL idle_clear_total: got %0d want 0", lines_total); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_running: got %0d want 0", running); end
        start_game(2); idle(12); clear(3); clear(0);
        total++; if (lines_total !== 10'd3) begin bad++; $display("FAIL zero_lines: got %0d want 3", lines_total); end
        clear(5); clear(7);
        total++; if (lines_total !== 10'd3) begin bad++; $display("FAIL big_lines: got %0d want 3", lines_total); end
        total++; if (dut.line_cnt_r !== 4'd3) begin bad++; $display("FAIL big_linecnt: got %0d want 3", dut.line_cnt_r); end
        game_start = 1'b1; start_lvl = 6'd4; clr_valid = 1'b1; clr_lines = 3'd4;
        step();
        game_start = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0;
        total++; if (lines_total !== 10'd0) begin bad++; $display("FAIL start_clear_total: got %0d want 0", lines_total); end
        total++; if (dut.level_r !== 6'd4) begin bad++; $display("FAIL start_clear_level: got %0d want 4", dut.level_r); end
        game_start = 1'b1; game_over = 1'b1;
        step();
        game_start = 1'b0; game_over = 1'b0;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL start_over_running: got %0d want 1", running); end
    endtask

    task automatic test_over();
        do_reset(); start_game(0); clear(3);
        clr_valid = 1'b1; clr_lines = 3'd2; game_over = 1'b1;
        step();
        clr_valid = 1'b0; clr_lines = 3'd0; game_over = 1'b0;
        total++; if (lines_total !== 10'd5) begin bad++; $display("FAIL over_clear_total: got %0d want 5", lines_total); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL over_running: got %0d want 0", running); end
        clear(4);
        total++; if (lines_total !== 10'd5) begin bad++; $display("FAIL over_frozen: got %0d want 5", lines_total); end
        start_game(1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL over_restart: got %0d want 1", running); end
    endtask

    task automatic test_saturate();
        do_reset(); start_game(0);
        for (int i = 0; i < 250; i++) clear(4);
        total++; if (lines_total !== 10'd999) begin bad++; $display("FAIL sat_total: got %0d want 999", lines_total); end
        clear(1);
        total++; if (lines_total !== 10'd999) begin bad++; $display("FAIL sat_hold: got %0d want 999", lines_total); end
        total++; if (dut.level_r !== 6'd63) begin bad++; $display("FAIL sat_level: got %0d want 63", dut.level_r); end
    endtask

    task automatic test_rst_mid_hold();
        int g;
        do_reset(); start_game(0); idle(12);
        clear(4); clear(4); clear(2); step();
        clear(4); clear(4); clear(2);
        rst = 1'b1; step(); rst = 1'b0;
        total++; if (lvl_gen !== 1'b0) begin bad++; $display("FAIL rst_hold_gen: got %0d want 0", lvl_gen); end
        total++; if (disp_level !== 6'd0) begin bad++; $display("FAIL rst_hold_disp: got %0d want 0", disp_level); end
        total++; if (lines_total !== 10'd0) begin bad++; $display("FAIL rst_hold_total: got %0d want 0", lines_total); end
        total++; if (drop_frames !== 6'd48) begin bad++; $display("FAIL rst_hold_drop: got %0d want 48", drop_frames); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_hold_running: got %0d want 0", running); end
        g = gen_count;
        idle(20);
        total++; if (gen_count != g) begin bad++; $display("FAIL rst_hold_late_gen: got %0d want %0d", gen_count, g); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            game_start = ($urandom_range(0, 49) == 0);
            game_over  = ($urandom_range(0, 79) == 0);
            clr_valid  = ($urandom_range(0, 2) == 0);
            clr_lines  = 3'($urandom_range(0, 7));
            start_lvl  = 6'($urandom_range(0, 63));
            step();
            total++; if (lvl_gen !== 1'(m_gen)) begin bad++; $display("FAIL rnd_gen @%0d: got %0d want %0d", cyc, lvl_gen, m_gen); end
            total++; if (disp_level !== 6'(m_disp)) begin bad++; $display("FAIL rnd_disp @%0d: got %0d want %0d", cyc, disp_level, m_disp); end
            total++; if (lines_total !== 10'(m_total)) begin bad++; $display("FAIL rnd_total @%0d: got %0d want %0d", cyc, lines_total, m_total); end
            total++; if (drop_frames !== 6'(m_drop)) begin bad++; $display("FAIL rnd_drop @%0d: got %0d want %0d", cyc, drop_frames, m_drop); end
            total++; if (running !== 1'(m_state == 1)) begin bad++; $display("FAIL rnd_running @%0d: got %0d want %0d", cyc, running, m_state == 1); end
        end
        rst = 1'b0; game_start = 1'b0; game_over = 1'b0; clr_valid = 1'b0; clr_lines = 3'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_level();
        test_back_to_back();
        test_max_level();
        test_illegal();
        test_over();
        test_saturate();
        test_rst_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
